alu_unit: RTL and testbench

- Execution unit directly downstream of the reservation station.
- Accepts one ready instruction per cycle (operands already resolved), computes the integer/branch result, and queues it in a small result FIFO.
- The FIFO drains onto the common data bus (CDB) under an external grant, which feeds the RS, LSB and ROB.
- `in_ready` back-pressures the RS.
- A flush on `jump_wrong` drops all in-flight work.

---
 rtl/alu_unit_if.sv | 33 +++
 rtl/alu_unit.sv | 195 +++++++++++++++++++
 tb/tb_alu_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_unit_if.sv
// Issue-side and CDB-side handshake bundle between the reservation station,
// the ALU execution unit and the CDB arbiter.
interface alu_unit_if #(
   parameter int ROB_W = 4,
   parameter int OP_W  = 6
);
   logic             in_valid;
   logic [OP_W-1:0]  in_op;
   logic [31:0]      in_rs1_value;
   logic [31:0]      in_rs2_value;
   logic [31:0]      in_imm;
   logic [31:0]      in_pc;
   logic [ROB_W-1:0] in_rd_rename;
   logic             in_ready;
   logic             cdb_grant;
   logic             out_valid;
   logic [31:0]      out_value;
   logic [ROB_W-1:0] out_rename;
   logic             out_jump;
   logic [31:0]      out_target;

   modport master (
      output in_valid, in_op, in_rs1_value, in_rs2_value, in_imm, in_pc,
             in_rd_rename, cdb_grant,
      input  in_ready, out_valid, out_value, out_rename, out_jump, out_target
   );

   modport slave (
      input  in_valid, in_op, in_rs1_value, in_rs2_value, in_imm, in_pc,
             in_rd_rename, cdb_grant,
      output in_ready, out_valid, out_value, out_rename, out_jump, out_target
   );
endinterface

// File: rtl/alu_unit.sv
// Integer/branch execution unit: one issue per cycle into an exec register,
// results queued in a small FIFO and broadcast on the CDB under grant.
package alu_unit_pkg;
   localparam logic [5:0] OP_LUI   = 6'd1;
   localparam logic [5:0] OP_AUIPC = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_JALR  = 6'd4;
   localparam logic [5:0] OP_BEQ   = 6'd5;
   localparam logic [5:0] OP_BNE   = 6'd6;
   localparam logic [5:0] OP_BLT   = 6'd7;
   localparam logic [5:0] OP_BGE   = 6'd8;
   localparam logic [5:0] OP_BLTU  = 6'd9;
   localparam logic [5:0] OP_BGEU  = 6'd10;
   localparam logic [5:0] OP_ADDI  = 6'd19;
   localparam logic [5:0] OP_SLTI  = 6'd20;
   localparam logic [5:0] OP_SLTIU = 6'd21;
   localparam logic [5:0] OP_XORI  = 6'd22;
   localparam logic [5:0] OP_ORI   = 6'd23;
   localparam logic [5:0] OP_ANDI  = 6'd24;
   localparam logic [5:0] OP_SLLI  = 6'd25;
   localparam logic [5:0] OP_SRLI  = 6'd26;
   localparam logic [5:0] OP_SRAI  = 6'd27;
   localparam logic [5:0] OP_ADD   = 6'd28;
   localparam logic [5:0] OP_SUB   = 6'd29;
   localparam logic [5:0] OP_SLL   = 6'd30;
   localparam logic [5:0] OP_SLT   = 6'd31;
   localparam logic [5:0] OP_SLTU  = 6'd32;
   localparam logic [5:0] OP_XOR   = 6'd33;
   localparam logic [5:0] OP_SRL   = 6'd34;
   localparam logic [5:0] OP_SRA   = 6'd35;
   localparam logic [5:0] OP_OR    = 6'd36;
   localparam logic [5:0] OP_AND   = 6'd37;
endpackage

module alu_unit
   import alu_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ROB_W = 4,
   parameter int OP_W  = 6
) (
   input logic       clk,
   input logic       rst,
   input logic       rdy,
   input logic       jump_wrong,
   alu_unit_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef struct packed {
      logic [31:0]      value;
      logic [ROB_W-1:0] rename;
      logic             jump;
      logic [31:0]      target;
   } entry_t;

   logic             flush;
   logic [OP_W-1:0]  op;
   logic [31:0]      rs1, rs2, imm, pc, pc4, pc_imm;
   entry_t           alu_res;
   logic             is_br, br_taken;

   logic             exec_valid_q, exec_valid_d;
   entry_t           exec_q, exec_d;
   entry_t           fifo_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] occ;

   logic             in_ready, accept, push, pop, out_valid;
   entry_t           head;

   assign flush  = rst | jump_wrong;
   assign op     = bus.in_op;
   assign rs1    = bus.in_rs1_value;
   assign rs2    = bus.in_rs2_value;
   assign imm    = bus.in_imm;
   assign pc     = bus.in_pc;
   assign pc4    = pc + 32'd4;
   assign pc_imm = pc + imm;

   // NOTE: every variable gets a default at the top of always_comb so no
   // path through the case statement can leave it unassigned (no latch).
   always_comb begin
      alu_res        = '0;
      alu_res.rename = bus.in_rd_rename;
      alu_res.target = pc4;
      is_br          = 1'b0;
      br_taken       = 1'b0;
      case (op)
         OP_ADD:   alu_res.value = rs1 + rs2;
         OP_ADDI:  alu_res.value = rs1 + imm;
         OP_SUB:   alu_res.value = rs1 - rs2;
         OP_AND:   alu_res.value = rs1 & rs2;
         OP_ANDI:  alu_res.value = rs1 & imm;
         OP_OR:    alu_res.value = rs1 | rs2;
         OP_ORI:   alu_res.value = rs1 | imm;
         OP_XOR:   alu_res.value = rs1 ^ rs2;
         OP_XORI:  alu_res.value = rs1 ^ imm;
         OP_SLL:   alu_res.value = rs1 << rs2[4:0];
         OP_SLLI:  alu_res.value = rs1 << imm[4:0];
         OP_SRL:   alu_res.value = rs1 >> rs2[4:0];
         OP_SRLI:  alu_res.value = rs1 >> imm[4:0];
         OP_SRA:   alu_res.value = 32'($signed(rs1) >>> rs2[4:0]);
         OP_SRAI:  alu_res.value = 32'($signed(rs1) >>> imm[4:0]);
         OP_SLT:   alu_res.value = {31'd0, $signed(rs1) < $signed(rs2)};
         OP_SLTI:  alu_res.value = {31'd0, $signed(rs1) < $signed(imm)};
         OP_SLTU:  alu_res.value = {31'd0, rs1 < rs2};
         OP_SLTIU: alu_res.value = {31'd0, rs1 < imm};
         OP_LUI:   alu_res.value = imm;
         OP_AUIPC: alu_res.value = pc_imm;
         OP_JAL: begin
            alu_res.value  = pc4;
            alu_res.jump   = 1'b1;
            alu_res.target = pc_imm;
         end
         OP_JALR: begin
            alu_res.value  = pc4;
            alu_res.jump   = 1'b1;
            alu_res.target = (rs1 + imm) & ~32'd1;
         end
         OP_BEQ:  begin is_br = 1'b1; br_taken = (rs1 == rs2);                  end
         OP_BNE:  begin is_br = 1'b1; br_taken = (rs1 != rs2);                  end
         OP_BLT:  begin is_br = 1'b1; br_taken = ($signed(rs1) <  $signed(rs2)); end
         OP_BGE:  begin is_br = 1'b1; br_taken = ($signed(rs1) >= $signed(rs2)); end
         OP_BLTU: begin is_br = 1'b1; br_taken = (rs1 <  rs2);                  end
         OP_BGEU: begin is_br = 1'b1; br_taken = (rs1 >= rs2);                  end
         default: ;
      endcase
      if (is_br) begin
         alu_res.jump   = br_taken;
         alu_res.target = br_taken ? pc_imm : pc4;
      end
   end

   // The exec register acts as one extra slot behind the FIFO: an issue is
   // accepted whenever the exec entry can move on, giving DEPTH+1 capacity.
   assign occ       = count_q + CNT_W'(exec_valid_q);
   assign in_ready  = (occ <= DEPTH_C);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & bus.cdb_grant;
   assign push      = exec_valid_q & ((count_q < DEPTH_C) | pop);
   assign accept    = bus.in_valid & in_ready & ~flush;

   always_comb begin
      exec_valid_d = accept | (exec_valid_q & ~push);
      exec_d       = accept ? alu_res : exec_q;
      head_d       = pop  ? head_q + PTR_W'(1) : head_q;
      tail_d       = push ? tail_q + PTR_W'(1) : tail_q;
      count_d      = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others regardless of block order.
   always_ff @(posedge clk) begin
      if (flush) begin
         exec_valid_q <= 1'b0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
      end else if (rdy) begin
         exec_valid_q <= exec_valid_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
      end
   end

   // NOTE: payload storage is not reset; valid bits and pointers alone decide
   // what is live, and the outputs are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (rdy && !flush) begin
         exec_q <= exec_d;
         if (push) fifo_q[tail_q] <= exec_q;
      end
   end

   assign head = fifo_q[head_q];

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.out_value  = out_valid ? head.value  : '0;
   assign bus.out_rename = out_valid ? head.rename : '0;
   assign bus.out_jump   = out_valid & head.jump;
   assign bus.out_target = out_valid ? head.target : '0;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: a table of opcode vectors plus hand-written sequences
// for latency, back-pressure, flush and freeze; results checked via a scoreboard.
module tb_alu_unit;
   import alu_unit_pkg::*;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] rs1, rs2, imm, pc;
      logic [31:0] value;
      logic        jump;
      logic [31:0] target;
   } vec_t;

   typedef struct {
      logic [31:0] value;
      logic [3:0]  rename;
      logic        jump;
      logic [31:0] target;
   } exp_t;

   logic clk = 1'b0;
   logic rst, rdy, jump_wrong;
   int   errors = 0;
   int   checks = 0;
   exp_t cur_exp;
   exp_t sb[$];
   vec_t vecs[$];

   alu_unit_if #(.ROB_W(4), .OP_W(6)) bus ();

   alu_unit #(.DEPTH(4), .ROB_W(4), .OP_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .jump_wrong (jump_wrong),
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [5:0] op, input logic [31:0] rs1, rs2, imm, pc,
                               input logic [31:0] value, input logic jump, input logic [31:0] target);
      vec_t v;
      v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
      v.value = value; v.jump = jump; v.target = target;
      return v;
   endfunction

   task automatic issue(input vec_t v, input logic [3:0] tag);
      bus.in_valid     = 1'b1;
      bus.in_op        = v.op;
      bus.in_rs1_value = v.rs1;
      bus.in_rs2_value = v.rs2;
      bus.in_imm       = v.imm;
      bus.in_pc        = v.pc;
      bus.in_rd_rename = tag;
      cur_exp.value    = v.value;
      cur_exp.rename   = tag;
      cur_exp.jump     = v.jump;
      cur_exp.target   = v.target;
   endtask

   task automatic issue_add(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      issue(mk(OP_ADD, a, b, 32'd0, 32'h1000, a + b, 1'b0, 32'h1004), tag);
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < max_cycles) begin
         tick();
         n++;
      end
      if (n >= max_cycles) check("drain_timeout", 32'(sb.size()), 32'd0);
      check("drained_out_valid", 32'(bus.out_valid), 32'd0);
   endtask

   // Scoreboard: expectations enter on accepted issue, leave on a granted broadcast.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst || jump_wrong) begin
         sb.delete();
      end else if (rdy) begin
         if (bus.out_valid && bus.cdb_grant) begin
            if (sb.size() == 0) begin
               check("cdb_unexpected", 32'(bus.out_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               check("cdb_value",  bus.out_value,        e.value);
               check("cdb_rename", 32'(bus.out_rename), 32'(e.rename));
               check("cdb_jump",   32'(bus.out_jump),   32'(e.jump));
               check("cdb_target", bus.out_target,       e.target);
            end
         end
         if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int accepted;

      vecs.push_back(mk(OP_ADD,   32'd5,        32'd7,        32'd0,        32'h1000, 32'd12,       1'b0, 32'h1004));
      vecs.push_back(mk(OP_SUB,   32'd5,        32'd7,        32'd0,        32'h1000, 32'hFFFFFFFE, 1'b0, 32'h1004));
      vecs.push_back(mk(OP_ADDI,  32'hFFFFFFFF, 32'd0,        32'd1,        32'h1000, 32'd0,        1'b0, 32'h1004));
      vecs.push_back(mk(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h1000, 32'hF000F000, 1'b0, 32'h1004));
      vecs.push_back(mk(OP_ORI,   32'h0F000000, 32'd0,        32'h000000F0, 32'h1000, 32'h0F0000F0, 1'b0, 32'h1004));
      vecs.push_back(mk(OP_XOR,   32'hAAAA5555, 32'hFFFF0000, 32'd0,        32'h1000, 32'h55555555, 1'b0, 32'h1004));
      vecs.push_back(mk(OP_SLL,   32'd1,        32'h23,       32'd0,        32'h1000, 32'd8,        1'b0, 32'h1004));
      vecs.push_back(mk(OP_SRA,   32'h80000000, 32'd4,        32'd0,        32'h1000, 32'hF8000000, 1'b0, 32'h1004));
      vecs.push_back(mk(OP_SRLI,  32'h80000000, 32'd0,        32'd4,        32'h1000, 32'h08000000, 1'b0, 32'h1004));
      vecs.push_back(mk(OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd0,        32'h1000, 32'd1,        1'b0, 32'h1004));
      vecs.push_back(mk(OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'h1000, 32'd0,        1'b0, 32'h1004));
      vecs.push_back(mk(OP_SLTIU, 32'd1,        32'd0,        32'hFFFFFFFF, 32'h1000, 32'd1,        1'b0, 32'h1004));
      vecs.push_back(mk(OP_LUI,   32'd0,        32'd0,        32'h12345000, 32'h1000, 32'h12345000, 1'b0, 32'h1004));
      vecs.push_back(mk(OP_AUIPC, 32'd0,        32'd0,        32'h2000,     32'h1000, 32'h3000,     1'b0, 32'h1004));
      vecs.push_back(mk(OP_JAL,   32'd0,        32'd0,        32'h10,       32'h200,  32'h204,      1'b1, 32'h210));
      vecs.push_back(mk(OP_JALR,  32'h1003,     32'd0,        32'd4,        32'h40,   32'h44,       1'b1, 32'h1006));
      vecs.push_back(mk(OP_BLT,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        1'b1, 32'h120));
      vecs.push_back(mk(OP_BLTU,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        1'b0, 32'h104));
      vecs.push_back(mk(OP_BEQ,   32'd3,        32'd3,        32'hFFFFFFF0, 32'h100,  32'd0,        1'b1, 32'hF0));
      vecs.push_back(mk(OP_BNE,   32'd3,        32'd3,        32'hFFFFFFF0, 32'h100,  32'd0,        1'b0, 32'h104));
      vecs.push_back(mk(OP_BGE,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        1'b0, 32'h104));
      vecs.push_back(mk(OP_BGEU,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        1'b1, 32'h120));
      vecs.push_back(mk(6'h3F,    32'd9,        32'd9,        32'd9,        32'h1000, 32'd0,        1'b0, 32'h1004));

      rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0;
      bus.in_valid = 1'b0; bus.cdb_grant = 1'b0; bus.in_op = '0;
      bus.in_rs1_value = '0; bus.in_rs2_value = '0; bus.in_imm = '0;
      bus.in_pc = '0; bus.in_rd_rename = '0;
      cur_exp = '{default: '0};
      tick(); tick();
      rst = 1'b0;
      check("reset_out_valid",  32'(bus.out_valid),  32'd0);
      check("reset_in_ready",   32'(bus.in_ready),   32'd1);
      check("reset_out_value",  bus.out_value,        32'd0);
      check("reset_out_rename", 32'(bus.out_rename), 32'd0);
      check("reset_out_jump",   32'(bus.out_jump),   32'd0);
      check("reset_out_target", bus.out_target,       32'd0);

      // Basic ADD latency: accepted at edge N, visible after N+1, gone after N+2.
      bus.cdb_grant = 1'b1;
      issue(vecs[0], 4'd3);
      tick();
      bus.in_valid = 1'b0;
      check("lat_n_out_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("lat_n1_out_valid", 32'(bus.out_valid), 32'd1);
      check("lat_n1_value",     bus.out_value,       32'd12);
      check("lat_n1_rename",    32'(bus.out_rename), 32'd3);
      tick();
      check("lat_n2_out_valid", 32'(bus.out_valid), 32'd0);

      // Opcode table, back-to-back issue with grant held.
      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i], 4'(i));
         tick();
      end
      bus.in_valid = 1'b0;
      drain(20);

      // Back-pressure: no grant, issue every cycle.
      bus.cdb_grant = 1'b0;
      accepted = 0;
      for (int c = 0; c < 8; c++) begin
         issue_add(32'(accepted), 32'd100, 4'(accepted));
         if (bus.in_ready) accepted++;
         tick();
      end
      bus.in_valid = 1'b0;
      check("bp_accepted", 32'(accepted), 32'd5);
      check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
      bus.cdb_grant = 1'b1;
      tick();
      bus.cdb_grant = 1'b0;
      check("bp_in_ready_after_pop", 32'(bus.in_ready), 32'd1);
      check("bp_head_after_pop", 32'(bus.out_rename), 32'd1);
      bus.cdb_grant = 1'b1;
      drain(20);

      // Flush with 3 queued + exec valid, plus a simultaneous issue.
      bus.cdb_grant = 1'b0;
      for (int i = 8; i < 12; i++) begin
         issue_add(32'(i), 32'd1, 4'(i));
         tick();
      end
      jump_wrong = 1'b1;
      bus.cdb_grant = 1'b1;
      issue_add(32'd12, 32'd1, 4'd12);
      tick();
      jump_wrong = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_out_valid",  32'(bus.out_valid),  32'd0);
      check("flush_in_ready",   32'(bus.in_ready),   32'd1);
      check("flush_out_value",  bus.out_value,        32'd0);
      check("flush_out_rename", 32'(bus.out_rename), 32'd0);
      check("flush_out_target", bus.out_target,       32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("flush_stays_empty", 32'(bus.out_valid), 32'd0);
      end

      // Freeze: rdy low with queued results and grant held.
      bus.cdb_grant = 1'b0;
      issue_add(32'd1, 32'd2, 4'd1);
      tick();
      issue_add(32'd10, 32'd20, 4'd2);
      tick();
      bus.in_valid = 1'b0;
      tick(); tick();
      rdy = 1'b0;
      bus.cdb_grant = 1'b1;
      issue_add(32'd50, 32'd50, 4'd7);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("freeze_out_valid",  32'(bus.out_valid),  32'd1);
         check("freeze_out_rename", 32'(bus.out_rename), 32'd1);
         check("freeze_out_value",  bus.out_value,        32'd3);
         check("freeze_out_target", bus.out_target,       32'h1004);
      end
      bus.in_valid = 1'b0;
      rdy = 1'b1;
      drain(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
